// File: rtl/cdb_arbiter_if.sv
// Request and broadcast bundle for the common data bus arbiter.
// master drives requests; slave is the arbiter.
interface cdb_arbiter_if #(
    parameter int REQ_CNT = 4,
    parameter int CDB_CNT = 2
);
    logic                     delete_tagged;
    logic [REQ_CNT-1:0]       req_valid;
    logic [REQ_CNT-1:0]       req_tag;
    logic [REQ_CNT*32-1:0]    req_data;
    logic [REQ_CNT*32-1:0]    req_address;
    logic [REQ_CNT*6-1:0]     req_arn;
    logic [REQ_CNT*6-1:0]     req_rrn;
    logic [REQ_CNT-1:0]       req_ready;
    logic [CDB_CNT-1:0]       cdb_valid;
    logic [CDB_CNT*32-1:0]    cdb_data;
    logic [CDB_CNT*32-1:0]    cdb_address;
    logic [CDB_CNT*6-1:0]     cdb_arn;
    logic [CDB_CNT*6-1:0]     cdb_rrn;

    modport master (
        output delete_tagged, req_valid, req_tag, req_data,
        output req_address, req_arn, req_rrn,
        input  req_ready, cdb_valid, cdb_data, cdb_address,
        input  cdb_arn, cdb_rrn
    );

    modport slave (
        input  delete_tagged, req_valid, req_tag, req_data,
        input  req_address, req_arn, req_rrn,
        output req_ready, cdb_valid, cdb_data, cdb_address,
        output cdb_arn, cdb_rrn
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to CDB_CNT result buses per cycle.
// Define CDB_ARB_FIXED_PRIO_EN to give requester 0 fixed top priority.
module cdb_arbiter #(
    parameter int REQ_CNT = 4,
    parameter int CDB_CNT = 2
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);
    localparam int PW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
`ifdef CDB_ARB_FIXED_PRIO_EN
    localparam int BASE = (REQ_CNT > 1) ? 1 : 0;
`else
    localparam int BASE = 0;
`endif
    localparam int SPAN = (REQ_CNT - BASE > 0) ? REQ_CNT - BASE : 1;

    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         ptr_nxt;
    logic [REQ_CNT-1:0]    squash;
    logic [REQ_CNT-1:0]    eligible;
    logic [REQ_CNT-1:0]    ready;
    logic [CDB_CNT-1:0]    hit;
    logic [PW-1:0]         sel [CDB_CNT];
    logic [CDB_CNT*32-1:0] data_d;
    logic [CDB_CNT*32-1:0] addr_d;
    logic [CDB_CNT*6-1:0]  arn_d;
    logic [CDB_CNT*6-1:0]  rrn_d;

    // Scan eligible requesters from rr_ptr and hand out bus slots in order.
    always_comb begin
        int cnt;
        int idx;
        int last;
        int start;
        int nxt;
        logic any;
        squash   = bus.req_valid & bus.req_tag & {REQ_CNT{bus.delete_tagged}};
        eligible = bus.req_valid & ~squash;
        ready    = squash;
        hit      = '0;
        for (int k = 0; k < CDB_CNT; k++) sel[k] = '0;
        cnt   = 0;
        idx   = 0;
        last  = 0;
        any   = 1'b0;
        nxt   = 0;
        start = int'(rr_ptr);
        if (start < BASE) start = BASE;
`ifdef CDB_ARB_FIXED_PRIO_EN
        if (eligible[0]) begin
            hit[0]   = 1'b1;
            ready[0] = 1'b1;
            cnt      = 1;
            any      = 1'b1;
        end
`endif
        for (int j = 0; j < SPAN; j++) begin
            idx = BASE + ((start - BASE + j) % SPAN);
            for (int i = 0; i < REQ_CNT; i++) begin
                if (i == idx && eligible[i] && cnt < CDB_CNT) begin
                    for (int k = 0; k < CDB_CNT; k++) begin
                        if (k == cnt) begin
                            hit[k] = 1'b1;
                            sel[k] = PW'(i);
                        end
                    end
                    ready[i] = 1'b1;
                    last     = i;
                    any      = 1'b1;
                    cnt      = cnt + 1;
                end
            end
        end
        if (any) begin
            nxt = (last + 1) % REQ_CNT;
            if (nxt < BASE) nxt = BASE;
            ptr_nxt = PW'(nxt);
        end else begin
            ptr_nxt = rr_ptr;
        end
        if (!reset) ready = '0;
        bus.req_ready = ready;
    end

    // Mux the granted requesters' payloads onto their bus slots.
    always_comb begin
        data_d = '0;
        addr_d = '0;
        arn_d  = '0;
        rrn_d  = '0;
        for (int k = 0; k < CDB_CNT; k++) begin
            for (int i = 0; i < REQ_CNT; i++) begin
                if (hit[k] && sel[k] == PW'(i)) begin
                    data_d[k*32 +: 32] = bus.req_data[i*32 +: 32];
                    addr_d[k*32 +: 32] = bus.req_address[i*32 +: 32];
                    arn_d[k*6 +: 6]    = bus.req_arn[i*6 +: 6];
                    rrn_d[k*6 +: 6]    = bus.req_rrn[i*6 +: 6];
                end
            end
        end
    end

    // Register the broadcast and advance the round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr          <= '0;
            bus.cdb_valid   <= '0;
            bus.cdb_data    <= '0;
            bus.cdb_address <= '0;
            bus.cdb_arn     <= '0;
            bus.cdb_rrn     <= '0;
        end else begin
            rr_ptr          <= ptr_nxt;
            bus.cdb_valid   <= hit;
            bus.cdb_data    <= data_d;
            bus.cdb_address <= addr_d;
            bus.cdb_arn     <= arn_d;
            bus.cdb_rrn     <= rrn_d;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: 4 requesters, 2 buses.
// Fixed-priority scenario runs when CDB_ARB_FIXED_PRIO_EN is defined.
module tb_cdb_arbiter;
    localparam int RN = 4;
    localparam int CN = 2;

    typedef struct packed {
        logic [1:0]  v;
        logic [63:0] d;
        logic [63:0] a;
        logic [11:0] r;
        logic [11:0] n;
    } bus_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    bus_t sbq[$];
    bus_t e;
    bus_t act;
    int   errors = 0;
    int   checks = 0;

    cdb_arbiter_if #(.REQ_CNT(RN), .CDB_CNT(CN)) bus ();

    cdb_arbiter #(.REQ_CNT(RN), .CDB_CNT(CN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pd(int i);
        return 32'h1000_0000 * (i + 1) + 32'h55;
    endfunction

    function automatic logic [31:0] pa(int i);
        return 32'h0000_4000 + 4 * i;
    endfunction

    function automatic bus_t grant(int u0, int u1);
        bus_t g;
        g = '0;
        if (u0 >= 0) begin
            g.v[0]     = 1'b1;
            g.d[31:0]  = pd(u0);
            g.a[31:0]  = pa(u0);
            g.r[5:0]   = 6'(u0 + 1);
            g.n[5:0]   = 6'(u0 + 40);
        end
        if (u1 >= 0) begin
            g.v[1]     = 1'b1;
            g.d[63:32] = pd(u1);
            g.a[63:32] = pa(u1);
            g.r[11:6]  = 6'(u1 + 1);
            g.n[11:6]  = 6'(u1 + 40);
        end
        return g;
    endfunction

    function automatic bus_t sample();
        bus_t s;
        s.v = bus.cdb_valid;
        s.d = bus.cdb_data;
        s.a = bus.cdb_address;
        s.r = bus.cdb_arn;
        s.n = bus.cdb_rrn;
        return s;
    endfunction

    task automatic drive(logic [3:0] v, logic [3:0] t, logic del);
        bus.req_valid     = v;
        bus.req_tag       = t;
        bus.delete_tagged = del;
    endtask

    task automatic test_reset();
        drive(4'b1111, 4'b0000, 1'b0);
        #12;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got %b want 0000", bus.req_ready);
        end
        checks++;
        if (sample() !== bus_t'(0)) begin
            errors++;
            $display("FAIL reset_cdb got %h want 0", sample());
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL reset_ptr got %0d want 0", dut.rr_ptr);
        end
        reset = 1'b1;
    endtask

    task automatic test_all_valid();
        drive(4'b1111, 4'b0000, 1'b0);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0011) begin
            errors++;
            $display("FAIL all_valid_ready got %b want 0011", bus.req_ready);
        end
        sbq.push_back(grant(0, 1));
        @(posedge clk); #1;
        e = sbq.pop_front();
        act = sample();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL all_valid_cdb got %h want %h", act, e);
        end
        checks++;
        if (dut.rr_ptr !== 2'd2) begin
            errors++;
            $display("FAIL all_valid_ptr got %0d want 2", dut.rr_ptr);
        end
    endtask

    task automatic test_wrap();
        drive(4'b0100, 4'b0000, 1'b0);
        #1;
        sbq.push_back(grant(2, -1));
        @(posedge clk); #1;
        e = sbq.pop_front();
        act = sample();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL wrap_setup_cdb got %h want %h", act, e);
        end
        drive(4'b1001, 4'b0000, 1'b0);
        #1;
        checks++;
        if (bus.req_ready !== 4'b1001) begin
            errors++;
            $display("FAIL wrap_ready got %b want 1001", bus.req_ready);
        end
        sbq.push_back(grant(3, 0));
        @(posedge clk); #1;
        e = sbq.pop_front();
        act = sample();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL wrap_cdb got %h want %h", act, e);
        end
        checks++;
        if (dut.rr_ptr !== 2'd1) begin
            errors++;
            $display("FAIL wrap_ptr got %0d want 1", dut.rr_ptr);
        end
    endtask

    task automatic test_idle();
        drive(4'b0000, 4'b1111, 1'b0);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ready got %b want 0000", bus.req_ready);
        end
        sbq.push_back(grant(-1, -1));
        @(posedge clk); #1;
        e = sbq.pop_front();
        act = sample();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL idle_cdb got %h want %h", act, e);
        end
        checks++;
        if (dut.rr_ptr !== 2'd1) begin
            errors++;
            $display("FAIL idle_ptr got %0d want 1", dut.rr_ptr);
        end
    endtask

    task automatic test_single();
        drive(4'b0001, 4'b0000, 1'b0);
        #1;
        sbq.push_back(grant(0, -1));
        @(posedge clk); #1;
        e = sbq.pop_front();
        act = sample();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL single_cdb got %h want %h", act, e);
        end
        checks++;
        if (dut.rr_ptr !== 2'd1) begin
            errors++;
            $display("FAIL single_ptr got %0d want 1", dut.rr_ptr);
        end
    endtask

    task automatic test_delete_tagged();
        drive(4'b1000, 4'b0000, 1'b0);
        #1;
        sbq.push_back(grant(3, -1));
        @(posedge clk); #1;
        e = sbq.pop_front();
        act = sample();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL delete_setup_cdb got %h want %h", act, e);
        end
        drive(4'b0111, 4'b0010, 1'b1);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0111) begin
            errors++;
            $display("FAIL delete_ready got %b want 0111", bus.req_ready);
        end
        sbq.push_back(grant(0, 2));
        @(posedge clk); #1;
        e = sbq.pop_front();
        act = sample();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL delete_cdb got %h want %h", act, e);
        end
        checks++;
        if (dut.rr_ptr !== 2'd3) begin
            errors++;
            $display("FAIL delete_ptr got %0d want 3", dut.rr_ptr);
        end
    endtask

    task automatic test_back_to_back();
        int u0 [3] = '{3, 1, 3};
        int u1 [3] = '{0, 2, 0};
        drive(4'b1111, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            sbq.push_back(grant(u0[c], u1[c]));
            @(posedge clk); #1;
            e = sbq.pop_front();
            act = sample();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL b2b_cdb[%0d] got %h want %h", c, act, e);
            end
        end
    endtask

    task automatic test_random(int start_ptr);
        int m_ptr;
        int n;
        int u;
        logic [3:0] v;
        logic [3:0] t;
        logic del;
        logic [3:0] sq;
        logic [3:0] el;
        logic [3:0] rdy;
        int g [2];
        m_ptr = start_ptr;
        for (int c = 0; c < 200; c++) begin
            v   = 4'($urandom);
            t   = 4'($urandom);
            del = ($urandom_range(0, 3) == 0);
            drive(v, t, del);
            sq  = v & t & {4{del}};
            el  = v & ~sq;
            rdy = sq;
            n   = 0;
            g   = '{-1, -1};
            for (int j = 0; j < 4; j++) begin
                u = (m_ptr + j) % 4;
                if (el[u] && n < 2) begin
                    rdy[u] = 1'b1;
                    g[n] = u;
                    n++;
                end
            end
            if (n > 0) m_ptr = (g[n-1] + 1) % 4;
            #1;
            checks++;
            if (bus.req_ready !== rdy) begin
                errors++;
                $display("FAIL rand_ready[%0d] got %b want %b", c, bus.req_ready, rdy);
            end
            sbq.push_back(grant(g[0], g[1]));
            @(posedge clk); #1;
            e = sbq.pop_front();
            act = sample();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL rand_cdb[%0d] got %h want %h", c, act, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(4'b1111, 4'b0000, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (bus.cdb_valid !== 2'b11) begin
            errors++;
            $display("FAIL midrst_pre got %b want 11", bus.cdb_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        sbq.delete();
        checks++;
        if (sample() !== bus_t'(0)) begin
            errors++;
            $display("FAIL midrst_cdb got %h want 0", sample());
        end
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_ready got %b want 0000", bus.req_ready);
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL midrst_ptr got %0d want 0", dut.rr_ptr);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.cdb_valid !== 2'b00) begin
            errors++;
            $display("FAIL midrst_replay got %b want 00", bus.cdb_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0011) begin
            errors++;
            $display("FAIL postrst_ready got %b want 0011", bus.req_ready);
        end
        sbq.push_back(grant(0, 1));
        @(posedge clk); #1;
        e = sbq.pop_front();
        act = sample();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL postrst_cdb got %h want %h", act, e);
        end
    endtask

    task automatic test_fixed_prio();
        logic [3:0] r [3] = '{4'b0011, 4'b0101, 4'b1001};
        drive(4'b1111, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.req_ready !== r[c]) begin
                errors++;
                $display("FAIL fixed_ready[%0d] got %b want %b", c, bus.req_ready, r[c]);
            end
            sbq.push_back(grant(0, c + 1));
            @(posedge clk); #1;
            e = sbq.pop_front();
            act = sample();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL fixed_cdb[%0d] got %h want %h", c, act, e);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < RN; i++) begin
            bus.req_data[i*32 +: 32]    = pd(i);
            bus.req_address[i*32 +: 32] = pa(i);
            bus.req_arn[i*6 +: 6]       = 6'(i + 1);
            bus.req_rrn[i*6 +: 6]       = 6'(i + 40);
        end
        test_reset();
`ifdef CDB_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_all_valid();
        test_wrap();
        test_idle();
        test_single();
        test_delete_tagged();
        test_back_to_back();
        test_random(1);
        test_reset_mid();
`endif
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter REQ_CNT, default 4: number of execution units requesting the common data bus.
REQ-002 SHALL have parameter CDB_CNT, default 2: number of common data buses driven.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port delete_tagged  input  1  squash request for speculative (tagged) results.
REQ-006 SHALL have port req_valid  input  REQ_CNT  per-unit result pending.
REQ-007 SHALL have port req_tag  input  REQ_CNT  per-unit result is speculative.
REQ-008 SHALL have port req_data  input  REQ_CNT*32  per-unit result value.
REQ-009 SHALL have port req_address  input  REQ_CNT*32  per-unit instruction address.
REQ-010 SHALL have port req_arn  input  REQ_CNT*6  per-unit architectural destination register.
REQ-011 SHALL have port req_rrn  input  REQ_CNT*6  per-unit renamed destination register.
REQ-012 SHALL have port req_ready  output  REQ_CNT  per-unit result accepted this cycle.
REQ-013 SHALL have port cdb_valid  output  CDB_CNT  per-bus broadcast valid.
REQ-014 SHALL have ports cdb_data/cdb_address (CDB_CNT*32), cdb_arn/cdb_rrn (CDB_CNT*6)  output  per-bus broadcast payload.

Function
REQ-015 SHALL keep round-robin pointer rr_ptr (clog2(REQ_CNT) bits, min 1); transfer = req_valid[i] & req_ready[i].
REQ-016 SHALL scan requesters from rr_ptr upward, wrapping modulo REQ_CNT (non-power-of-2 included), granting first min(CDB_CNT, eligible count) eligible requesters.
REQ-017 SHALL map k-th grant in scan order to bus k; unused buses get no grant.
REQ-018 SHALL drive req_ready combinationally, same cycle as req_valid; req_ready[i] never high when req_valid[i] low.
REQ-019 SHALL register granted payload onto cdb_* at next rising edge: latency exactly 1 cycle; cdb_valid high one cycle per grant.
REQ-020 SHALL drive cdb_valid[k]=0 and cdb_data/address/arn/rrn[k]=0 for buses with no grant.
REQ-021 SHALL set rr_ptr = (index of last bus-consuming grant + 1) mod REQ_CNT when any grant; else hold.
REQ-022 SHALL, while delete_tagged=1, assert req_ready for every valid requester with req_tag=1 without consuming bus slot, broadcasting, or affecting rr_ptr.
REQ-023 SHALL, while delete_tagged=0, treat tagged requests as ordinary requests.
REQ-024 SHALL grant every valid requester when REQ_CNT <= CDB_CNT.
REQ-025 SHALL guarantee requester continuously valid is granted within ceil(REQ_CNT/CDB_CNT) cycles.
REQ-026 SHALL not check payload stability; requester holds payload stable while valid & !ready.

Reset
REQ-027 SHALL, on reset=0, immediately clear rr_ptr, all cdb_valid and cdb payload to 0, and force req_ready to 0.
REQ-028 SHALL permit grants in the first cycle after reset deasserts; reset mid-broadcast drops it without later replay.

Configuration
REQ-029 SHALL, with CDB_ARB_FIXED_PRIO_EN defined, always grant requester 0 first (bus 0) when valid, arbitrating remaining buses round-robin over 1..REQ_CNT-1, rr_ptr never pointing at 0.
REQ-030 SHALL, without CDB_ARB_FIXED_PRIO_EN, use pure round-robin over all requesters per REQ-016..021.

Verification
REQ-031 SHALL cover: reset release, req_valid=4'b1111, rr_ptr=0 -> req_ready=4'b0011; next edge bus0 = unit0 payload, bus1 = unit1; rr_ptr=2.
REQ-032 SHALL cover: req_valid=4'b1001, rr_ptr=3 -> wrap, bus0=unit3, bus1=unit0, rr_ptr=1.
REQ-033 SHALL cover: delete_tagged=1, req_valid=4'b0111, req_tag=4'b0010, rr_ptr=0 -> req_ready=4'b0111; bus0=unit0, bus1=unit2; rr_ptr=3.
REQ-034 SHALL cover: req_valid=4'b0000 -> cdb_valid=2'b00, all cdb payload 0, rr_ptr unchanged.
REQ-035 SHALL cover: reset=0 asserted mid-cycle with req_valid=4'b1111 -> cdb_valid=0 and req_ready=0 immediately, rr_ptr=0.
REQ-036 SHALL cover: CDB_ARB_FIXED_PRIO_EN, req_valid=4'b1111 held 3 cycles -> unit0 on bus0 each cycle; bus1 = unit1, unit2, unit3 in order.
